serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial 4-bit two's complement subtractor (Diff = A - B). The subtraction
// is done as A + ~B + 1: the carry flop is preset to 1 on launch and one bit
// is processed per clock, LSB first, over four RUN cycles.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   launch request, only honoured in IDLE
//   A         in   4-bit minuend (two's complement), latched on launch
//   B         in   4-bit subtrahend (two's complement), latched on launch
//   Diff      out  registered 4-bit result
//   overflow  out  signed overflow of the last result
//   borrow    out  unsigned borrow of the last result (A < B unsigned)
//   busy      out  high while the FSM is in RUN
//   done      out  one-cycle pulse when Diff/overflow/borrow are updated
//
// Build option
//   SATURATE_EN  when defined, a signed overflow clamps Diff to 4'b0111
//                (positive minuend) or 4'b1000 (negative minuend).
//
// Timing: IDLE -> RUN (4 cycles) -> DONE (1 cycle) -> IDLE (at least 1
// cycle), so a held start relaunches every 6 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Diff,
  output logic       overflow,
  output logic       borrow,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] res_q, res_d;
  logic [1:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [3:0] diff_q, diff_d;
  logic       ovf_q, ovf_d;
  logic       brw_q, brw_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Full-adder slice on the current bit pair, subtrahend inverted.
  logic       a_i, nb_i, sum_i, cout_i;
  logic [3:0] wrapped;

  assign a_i     = a_q[0];
  assign nb_i    = ~b_q[0];
  assign sum_i   = a_i ^ nb_i ^ carry_q;
  assign cout_i  = (a_i & nb_i) | (a_i & carry_q) | (nb_i & carry_q);
  assign wrapped = {sum_i, res_q[3:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    brw_d   = brw_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          res_d   = 4'd0;
          cnt_d   = 2'd0;
          carry_d = 1'b1;   // the "+1" of the two's complement negation
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[3:1]};
        b_d     = {1'b0, b_q[3:1]};
        res_d   = wrapped;
        carry_d = cout_i;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          // On the last bit a_q[0]/b_q[0] hold the latched sign bits, and
          // sum_i is the result sign bit.
          ovf_d   = (a_i != b_q[0]) && (sum_i != a_i);
          brw_d   = ~cout_i;
`ifdef SATURATE_EN
          if ((a_i != b_q[0]) && (sum_i != a_i))
            diff_d = a_i ? 4'b1000 : 4'b0111;
          else
            diff_d = wrapped;
`else
          diff_d  = wrapped;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered so they line up exactly with the state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      res_q   <= 4'd0;
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
      diff_q  <= 4'd0;
      ovf_q   <= 1'b0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Diff     = diff_q;
  assign overflow = ovf_q;
  assign borrow   = brw_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor. Stimulus pushes the hand-computed
// expected {Diff, overflow, borrow} into a queue when it launches an
// operation; an independent monitor pops and compares on every done pulse.
// Also checks reset values, busy length, done latency, held outputs, reset
// abort and back-to-back spacing. Honours SATURATE_EN like the design.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] Diff;
  logic       overflow;
  logic       borrow;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] diff;
    logic       ovf;
    logic       brw;
  } exp_t;

  exp_t exp_q[$];

  serial_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Diff     (Diff),
    .overflow (overflow),
    .borrow   (borrow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 with Diff=%b ovf=%b brw=%b, expected no done",
                 Diff, overflow, borrow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if ({Diff, overflow, borrow} !== {e.diff, e.ovf, e.brw}) begin
          miscompares++;
          $display("FAIL result: got Diff=%b ovf=%b brw=%b, expected Diff=%b ovf=%b brw=%b",
                   Diff, overflow, borrow, e.diff, e.ovf, e.brw);
        end else begin
          $display("result Diff=%b ovf=%b brw=%b ok", Diff, overflow, borrow);
        end
      end
    end
  end

  // One operation: start pulse for one edge, then watch 8 cycles for busy
  // length, done position and held result. With poke set, further start
  // requests with fresh operands are issued during RUN and must be ignored.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eo, input logic eb,
                        input bit poke);
    int busy_cnt;
    int done_cnt;
    int done_at;
    exp_t e;
    e.diff = ed; e.ovf = eo; e.brw = eb;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);            // start edge
    #1;
    start = 1'b0;
    A = ~a; B = ~b;            // operands are don't-care from here on
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_at = i; end
      if (poke && (i == 1 || i == 2)) begin
        start = 1'b1; A = 4'b0001; B = 4'b0110;
      end else begin
        start = 1'b0;
      end
    end
    $display("op A=%b B=%b: busy %0d cycles, %0d done at cycle %0d", a, b, busy_cnt, done_cnt, done_at);
    check("busy_cycles", 8'(busy_cnt), 8'd4);
    check("done_count", 8'(done_cnt), 8'd1);
    check("done_latency", 8'(done_at), 8'd5);
    check("held_result", {2'b00, Diff, overflow, borrow}, {2'b00, ed, eo, eb});
  endtask

  initial begin : stim
    int done_cnt;
    int first_done;
    int last_done;
    int gap_bad;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {1'b0, Diff, overflow, borrow, busy, done}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SATURATE_EN
    run_op(4'b0010, 4'b0011, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_op(4'b0111, 4'b1011, 4'b0111, 1'b1, 1'b1, 1'b0);
    run_op(4'b1001, 4'b0111, 4'b1000, 1'b1, 1'b0, 1'b0);
    run_op(4'b1000, 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0);
    run_op(4'b0000, 4'b1000, 4'b0111, 1'b1, 1'b1, 1'b0);
`else
    run_op(4'b0010, 4'b0011, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_op(4'b0111, 4'b1011, 4'b1100, 1'b1, 1'b1, 1'b0);
    run_op(4'b1001, 4'b0111, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_op(4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0);
    run_op(4'b0000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
`endif
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0);
    // Start requests during RUN are ignored and not queued.
    run_op(4'b1101, 4'b1011, 4'b0010, 1'b0, 1'b0, 1'b1);

    // Reset abort in the 2nd RUN cycle: no done, outputs cleared.
    @(negedge clk);
    A = 4'b0111; B = 4'b0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);            // RUN cycle 1
    @(negedge clk);            // RUN cycle 2
    rst_n = 1'b0;
    @(negedge clk);
    $display("abort: Diff=%b ovf=%b brw=%b busy=%b done=%b", Diff, overflow, borrow, busy, done);
    check("abort_outputs", {1'b0, Diff, overflow, borrow, busy, done}, 8'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 8'(done_cnt), 8'd0);
    run_op(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0);

    // start held for 15 edges: launches at edge 0, 6 and 12.
    @(negedge clk);
    A = 4'b0101; B = 4'b0101; start = 1'b1;
    for (int n = 0; n < 3; n++) exp_q.push_back('{diff: 4'b0000, ovf: 1'b0, brw: 1'b0});
    done_cnt = 0; first_done = 0; last_done = 0; gap_bad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 15) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
        else if (i - last_done != 6) gap_bad++;
        last_done = i;
      end
    end
    $display("back-to-back: %0d dones, first at %0d, last at %0d", done_cnt, first_done, last_done);
    check("b2b_done_count", 8'(done_cnt), 8'd3);
    check("b2b_spacing_errors", 8'(gap_bad), 8'd0);
    check("b2b_first_latency", 8'(first_done), 8'd5);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run.
  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish by 100000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
